// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter between N_REQ byte producers.
// Each granted byte is written once, followed to completion, then acknowledged with done.
module uart_tx_arbiter #(
    parameter int N_REQ        = 4,
    parameter int BUSY_TIMEOUT = 16,
    parameter int IDW          = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_REQ-1:0]     req,
    input  logic [8*N_REQ-1:0]   req_data,
    output logic [N_REQ-1:0]     grant,
    output logic [N_REQ-1:0]     done,
    output logic [7:0]           tx_data,
    output logic                 tx_wr,
    input  logic                 tx_busy,
    output logic [IDW-1:0]       active_id,
    output logic                 busy_o
);

    localparam int CW = $clog2(BUSY_TIMEOUT) + 1;

    typedef enum logic [1:0] {IDLE, LOAD, WAIT_BUSY, WAIT_DONE} state_t;

    state_t             state_q, state_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [N_REQ-1:0]   done_q, done_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               tx_wr_q, tx_wr_d;
    logic [IDW-1:0]     active_id_q, active_id_d;
    logic [IDW-1:0]     last_q, last_d;
    logic               busy_q, busy_d;
    logic [CW-1:0]      cnt_q, cnt_d;

    logic [IDW-1:0]     sel;
    logic               sel_vld;

    // Scan starts just after the previous owner so the last winner ranks lowest.
    always_comb begin : pick
        int t;
        logic [IDW-1:0] cand;
        t       = 0;
        cand    = '0;
        sel     = '0;
        sel_vld = 1'b0;
        for (int i = 1; i <= N_REQ; i++) begin
            t = int'(last_q) + i;
            if (t >= N_REQ) t = t - N_REQ;
            cand = IDW'(t);
            if (!sel_vld && req[cand]) begin
                sel     = cand;
                sel_vld = 1'b1;
            end
        end
    end

    always_comb begin : next
        state_d     = state_q;
        grant_d     = '0;
        done_d      = '0;
        tx_data_d   = tx_data_q;
        tx_wr_d     = 1'b0;
        active_id_d = active_id_q;
        last_d      = last_q;
        busy_d      = busy_q;
        cnt_d       = cnt_q;
        case (state_q)
            IDLE: begin
                if (sel_vld && !tx_busy) begin
                    grant_d[sel] = 1'b1;
                    tx_data_d    = req_data[{sel, 3'b000} +: 8];
                    active_id_d  = sel;
                    last_d       = sel;
                    busy_d       = 1'b1;
                    state_d      = LOAD;
                end
            end
            LOAD: begin
                tx_wr_d = 1'b1;
                cnt_d   = '0;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                // A UART that finished before busy was ever seen is covered by the timeout.
                if (tx_busy) begin
                    state_d = WAIT_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_d == CW'(BUSY_TIMEOUT - 1)) state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    done_d[active_id_q] = 1'b1;
                    busy_d              = 1'b0;
                    state_d             = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            done_q      <= '0;
            tx_data_q   <= 8'h00;
            tx_wr_q     <= 1'b0;
            active_id_q <= '0;
            last_q      <= IDW'(N_REQ - 1);
            busy_q      <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            done_q      <= done_d;
            tx_data_q   <= tx_data_d;
            tx_wr_q     <= tx_wr_d;
            active_id_q <= active_id_d;
            last_q      <= last_d;
            busy_q      <= busy_d;
            cnt_q       <= cnt_d;
        end
    end

    assign grant     = grant_q;
    assign done      = done_q;
    assign tx_data   = tx_data_q;
    assign tx_wr     = tx_wr_q;
    assign active_id = active_id_q;
    assign busy_o    = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus randomized traffic, all outputs
// compared every cycle against a transaction-level reference model.
module tb_uart_tx_arbiter;

    localparam int N   = 4;
    localparam int BT  = 16;
    localparam int IDW = 2;

    logic           clk;
    logic           reset;
    logic [N-1:0]   req;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   grant;
    logic [N-1:0]   done;
    logic [7:0]     tx_data;
    logic           tx_wr;
    logic           tx_busy;
    logic [IDW-1:0] active_id;
    logic           busy_o;

    uart_tx_arbiter #(.N_REQ(N), .BUSY_TIMEOUT(BT), .IDW(IDW)) dut (
        .clk(clk), .reset(reset), .req(req), .req_data(req_data),
        .grant(grant), .done(done), .tx_data(tx_data), .tx_wr(tx_wr),
        .tx_busy(tx_busy), .active_id(active_id), .busy_o(busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Inputs as the DUT saw them at the edge just taken
    logic [N-1:0]   req_prev;
    logic [8*N-1:0] data_prev;
    logic           busy_prev;
    logic           reset_prev;

    // Reference model: one outstanding transfer described by its grant cycle
    logic           m_busy;
    int             m_owner;
    int             m_last;
    int             m_g;
    logic           m_wd;
    logic [7:0]     m_data;
    int             wait_cnt [N];

    // Stimulus helpers: 0 = tx_busy driven by hand, 1 = fixed-length uart, 2 = random-length uart
    int   uart_mode = 0;
    int   uart_len  = 3;
    int   uart_cnt  = 0;
    logic auto_req  = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_step();
        logic [N-1:0] eg, ed;
        logic         ew, found;
        int           w, k, c, maxw;
        eg = '0; ed = '0; ew = 1'b0; found = 1'b0; w = 0; maxw = 0;
        if (reset_prev) begin
            m_busy = 1'b0; m_last = N - 1; m_data = 8'h00; m_wd = 1'b0; m_owner = 0;
            for (int i = 0; i < N; i++) wait_cnt[i] = 0;
            check("reset_outputs", {grant, done, tx_data, tx_wr, active_id, busy_o}, '0);
            return;
        end
        if (!m_busy) begin
            if (req_prev != '0 && !busy_prev) begin
                for (int i = 1; i <= N; i++) begin
                    c = (m_last + i) % N;
                    if (!found && req_prev[c]) begin w = c; found = 1'b1; end
                end
                eg[w]   = 1'b1;
                m_owner = w; m_last = w; m_g = cyc; m_wd = 1'b0; m_busy = 1'b1;
                m_data  = data_prev[8*w +: 8];
                for (int i = 0; i < N; i++) begin
                    if (i == w || !req_prev[i]) wait_cnt[i] = 0;
                    else wait_cnt[i]++;
                    if (wait_cnt[i] > maxw) maxw = wait_cnt[i];
                end
                check("fair_wait", (maxw <= N - 1), 1'b1);
            end
        end else begin
            k = cyc - m_g;
            if (k == 1) ew = 1'b1;
            else if (!m_wd) begin
                if (busy_prev || k >= BT) m_wd = 1'b1;
            end else if (!busy_prev) begin
                ed[m_owner] = 1'b1;
                m_busy      = 1'b0;
            end
        end
        check("grant", grant, eg);
        check("done", done, ed);
        check("tx_wr", tx_wr, ew);
        check("busy_o", busy_o, m_busy);
        check("tx_data", tx_data, m_data);
        if (m_busy) check("active_id", active_id, m_owner);
    endtask

    task automatic step();
        req_prev = req; data_prev = req_data; busy_prev = tx_busy; reset_prev = reset;
        @(posedge clk);
        #1;
        cyc++;
        model_step();
        if (uart_mode != 0) begin
            if (tx_wr) uart_cnt = (uart_mode == 1) ? uart_len : int'($urandom_range(0, 6));
            else if (uart_cnt > 0) uart_cnt--;
            tx_busy = (uart_cnt > 0);
        end
        if (auto_req) begin
            for (int i = 0; i < N; i++) begin
                if (grant[i]) req[i] = 1'b0;
                else if (!req[i] && $urandom_range(0, 3) == 0) begin
                    req[i] = 1'b1;
                    req_data[8*i +: 8] = 8'($urandom);
                end
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; req = '0; tx_busy = 1'b0; uart_cnt = 0;
        step(); step();
        reset = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int t;
        t = 0;
        while (busy_o && t < 60) begin step(); t++; end
        check(tag, busy_o, 1'b0);
    endtask

    logic [N-1:0] g_seen;
    logic         flag;
    int           t;

    initial begin
        reset = 1'b1; req = '0; req_data = '0; tx_busy = 1'b0;
        m_busy = 1'b0; m_last = N - 1; m_data = 8'h00; m_wd = 1'b0; m_owner = 0; m_g = 0;
        for (int i = 0; i < N; i++) wait_cnt[i] = 0;

        // Single request with a uart busy for 20 cycles
        do_reset();
        req = 4'b0010; req_data = {8'h00, 8'h00, 8'h41, 8'h00};
        step();
        check("single_grant", grant, 4'b0010);
        req = '0;
        step();
        check("single_wr", {tx_wr, tx_data}, {1'b1, 8'h41});
        tx_busy = 1'b1;
        repeat (20) step();
        check("single_no_early_done", done, 4'b0000);
        tx_busy = 1'b0;
        step();
        check("single_done", done, 4'b0010);
        step();
        check("single_release", {busy_o, done}, 5'b0);

        // All four held continuously: strict rotation 30,31,32,33,30,31
        do_reset();
        uart_mode = 1; uart_len = 3;
        req = 4'b1111; req_data = {8'h33, 8'h32, 8'h31, 8'h30};
        for (int k = 0; k < 6; k++) begin
            t = 0;
            while (!tx_wr && t < 40) begin step(); t++; end
            check("rr_wr_seen", tx_wr, 1'b1);
            check("rr_order", tx_data, 8'h30 + 8'(k % 4));
            step();
        end
        req = '0;
        wait_idle("rr_idle");

        // Fairness across the wrap: last=3, req=1001 -> 0, 3, 0
        do_reset();
        uart_mode = 1; uart_len = 2;
        req = 4'b1001; req_data = {8'hA3, 8'h00, 8'h00, 8'hA0};
        for (int k = 0; k < 3; k++) begin
            t = 0;
            g_seen = '0;
            while (g_seen == '0 && t < 40) begin step(); g_seen = grant; t++; end
            check("wrap_grant", g_seen, (k == 1) ? 4'b1000 : 4'b0001);
        end
        req = '0;
        wait_idle("wrap_idle");

        // Timeout: uart never goes busy
        do_reset();
        uart_mode = 0; tx_busy = 1'b0;
        req = 4'b0001; req_data = {24'h0, 8'h5A};
        step();
        check("to_grant", grant, 4'b0001);
        req = '0;
        step();
        check("to_wr", tx_wr, 1'b1);
        flag = 1'b0;
        for (int j = 1; j < BT; j++) begin
            step();
            if (done != '0) flag = 1'b1;
        end
        check("to_no_early_done", flag, 1'b0);
        step();
        check("to_done", done, 4'b0001);

        // Reset while waiting for the uart to finish
        do_reset();
        req = 4'b0100; req_data = {8'h00, 8'h77, 8'h00, 8'h00};
        step();
        check("rst_grant", grant, 4'b0100);
        req = '0;
        step();
        tx_busy = 1'b1;
        step(); step(); step();
        check("rst_owned", {busy_o, active_id}, {1'b1, 2'd2});
        reset = 1'b1;
        step();
        check("rst_clear", {grant, done, tx_data, tx_wr, active_id, busy_o}, '0);
        reset = 1'b0; tx_busy = 1'b0;
        req = 4'b1101; req_data = {8'hD3, 8'hD2, 8'h00, 8'hD0};
        step();
        check("rst_restart_prio", {grant, done}, {4'b0001, 4'b0000});
        req = '0;
        wait_idle("rst_idle");

        // Foreign busy while idle holds off the grant
        do_reset();
        tx_busy = 1'b1;
        req = 4'b0100; req_data = {8'h00, 8'h62, 8'h00, 8'h00};
        flag = 1'b0;
        repeat (5) begin
            step();
            if (grant != '0) flag = 1'b1;
        end
        check("foreign_no_grant", flag, 1'b0);
        tx_busy = 1'b0;
        step();
        check("foreign_grant", grant, 4'b0100);
        req = '0;
        wait_idle("foreign_idle");

        // Randomized traffic against the model
        do_reset();
        uart_mode = 2; auto_req = 1'b1;
        repeat (1500) step();
        auto_req = 1'b0; req = '0;
        wait_idle("random_idle");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART transmitter (tx_data / tx_wr / tx_busy interface of the uart peripheral) between N_REQ byte producers.
- Arbitration is round-robin.
- For each granted byte the block drives tx_data and tx_wr, waits for the transmitter to finish, then returns a completion pulse to the owner.
- Sits between the application logic and the uart instance, in place of direct tx_wr driving.

Parameters:
N_REQ, 4, number of requesters (2..8)
BUSY_TIMEOUT, 16, max cycles to wait for tx_busy rising after tx_wr before treating the byte as sent
IDW, 2, width of the requester index (ceil(log2(N_REQ)), min 1)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
req  input  N_REQ  level request per requester; held until its grant pulse
req_data  input  8*N_REQ  byte per requester; requester i occupies bits [8i+7:8i]; must be stable while req[i]=1
grant  output  N_REQ  one-hot, one-cycle pulse: byte of requester i latched
done  output  N_REQ  one-hot, one-cycle pulse: byte of requester i finished transmitting
tx_data  output  8  byte to uart transmitter
tx_wr  output  1  one-cycle write strobe to uart
tx_busy  input  1  uart transmitter busy
active_id  output  IDW  index of current owner, valid while busy_o=1
busy_o  output  1  arbiter owns the transmitter

Behaviour:
- Reset: all outputs 0; tx_data=8'h00; state IDLE; round-robin pointer last=N_REQ-1, so requester 0 has top priority first. Reset asserted in any state aborts immediately. No done is issued for an aborted byte.
- States: IDLE, LOAD, WAIT_BUSY, WAIT_DONE.
- IDLE:
  - If any req bit is set and tx_busy=0, select the first set bit scanning last+1, last+2, ... modulo N_REQ.
  - Same cycle, registered: grant[sel] pulses, tx_data <= req_data[sel], active_id <= sel, last <= sel, busy_o <= 1. Go to LOAD.
  - If tx_busy=1 in IDLE (foreign activity), stay in IDLE and issue no grant.
- LOAD: tx_wr=1 for exactly this one cycle; tx_data stable. Go to WAIT_BUSY with the timeout counter cleared.
- WAIT_BUSY:
  - tx_busy=1: go to WAIT_DONE.
  - Otherwise increment the counter. When the counter reaches BUSY_TIMEOUT-1, go to WAIT_DONE; this covers a uart that finished before being sampled.
- WAIT_DONE: when tx_busy=0, pulse done[active_id] for one cycle, clear busy_o, go to IDLE.
- Latency:
  - req rise to grant: 1 cycle.
  - grant to tx_wr: 1 cycle.
  - tx_busy fall to done: 1 cycle.
  - done to next grant: at least 1 cycle (IDLE revisited).
- tx_data holds its value until the next grant; it never changes while busy_o=1.
- Requests arriving while busy_o=1 are held, not dropped. A requester deasserting req before its grant is simply skipped.
- Simultaneous requests: exactly one grant. A requester granted last has lowest priority in the next arbitration. No requester waits more than N_REQ-1 other transfers.
- Pointer wrap: after index N_REQ-1, the scan continues at index 0.
- grant and done are never asserted for more than one bit and never for more than one cycle per transfer.

Test Plan:
- Single request: req=4'b0010, data1=8'h41, uart busy for 20 cycles -> grant=0010 in cycle 1; tx_wr with tx_data=8'h41 in cycle 2; done=0010 one cycle after tx_busy falls; busy_o then 0.
- All four requesters held continuously with data 8'h30..8'h33 -> tx_wr order 30, 31, 32, 33, 30, ...; each done precedes the next grant.
- Fairness after wrap: last=3, req=1001 -> grant to 0, then 3, then 0; neither starves.
- Timeout: tx_busy tied 0, req=0001 -> done=0001 exactly BUSY_TIMEOUT cycles after entering WAIT_BUSY; no hang.
- Reset mid-transfer: reset in WAIT_DONE -> next cycle all outputs 0, no done pulse, and the next arbitration starts from requester 0.
- Foreign busy: tx_busy=1 while idle with req=0100 -> no grant until tx_busy=0, then grant=0100 on the following cycle.
